// File: rtl/dmem_handshake_responder.sv
// Multi-cycle data memory behind a valid/ready request port with a pulsed (or held) response.
// Optional macro DMEM_BACKPRESSURE_EN adds resp_ready and holds the response until it is taken.
module dmem_handshake_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0100_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    input  logic        w_enable,
    input  logic [1:0]  access_size,
    input  logic        RdUn,
`ifdef DMEM_BACKPRESSURE_EN
    input  logic        resp_ready,
`endif
    output logic        resp_valid,
    output logic [31:0] data_out,
    output logic        resp_error
);

    localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] ERR_WORD = 32'hbadbadff;

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic [31:0] lat_addr;
    logic [31:0] lat_data;
    logic        lat_we;
    logic [1:0]  lat_size;
    logic        lat_rdun;

    // Array is not touched by reset; it starts out all zero.
    logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

    logic [31:0]   offset;
    logic          out_of_range;
    logic          misaligned;
    logic          access_err;
    logic [IW-1:0] word_idx;
    logic [31:0]   rd_word;
    logic [7:0]    sel_byte;
    logic [15:0]   sel_half;
    logic [31:0]   ld_word;
    logic [31:0]   wr_word;
    logic          do_access;

    always_comb begin
        offset       = lat_addr - BASE_ADDR;
        out_of_range = (lat_addr < BASE_ADDR) || ((offset >> 2) >= 32'(DEPTH_WORDS));
        case (lat_size)
            2'd1:    misaligned = lat_addr[0];
            2'd2:    misaligned = |lat_addr[1:0];
            2'd3:    misaligned = 1'b1;
            default: misaligned = 1'b0;
        endcase
        access_err = out_of_range || misaligned;
        word_idx   = offset[IW+1:2];
        rd_word    = mem[word_idx];
        sel_byte   = rd_word[{lat_addr[1:0], 3'b000} +: 8];
        sel_half   = rd_word[{lat_addr[1], 4'b0000} +: 16];

        case (lat_size)
            2'd0:    ld_word = {{24{~lat_rdun & sel_byte[7]}}, sel_byte};
            2'd1:    ld_word = {{16{~lat_rdun & sel_half[15]}}, sel_half};
            default: ld_word = rd_word;
        endcase

        // Stores rewrite only the addressed lanes of the current word.
        wr_word = rd_word;
        case (lat_size)
            2'd0:    wr_word[{lat_addr[1:0], 3'b000} +: 8] = lat_data[7:0];
            2'd1:    wr_word[{lat_addr[1], 4'b0000} +: 16] = lat_data[15:0];
            default: wr_word = lat_data;
        endcase

        do_access = (state == WAIT) && (wait_cnt == 4'd0);
    end

    always_ff @(posedge clk) begin
        if (do_access && lat_we && !access_err) begin
            mem[word_idx] <= wr_word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            data_out   <= '0;
            resp_error <= 1'b0;
            wait_cnt   <= '0;
            lat_addr   <= '0;
            lat_data   <= '0;
            lat_we     <= 1'b0;
            lat_size   <= '0;
            lat_rdun   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_addr  <= address;
                        lat_data  <= data_in;
                        lat_we    <= w_enable;
                        lat_size  <= access_size;
                        lat_rdun  <= RdUn;
                        wait_cnt  <= 4'(LATENCY - 1);
                        req_ready <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        resp_valid <= 1'b1;
                        resp_error <= access_err;
                        data_out   <= access_err ? ERR_WORD : (lat_we ? 32'd0 : ld_word);
                        state      <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
`ifdef DMEM_BACKPRESSURE_EN
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
`else
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
